// File: rtl/spi_master_cmd.sv
// Command-driven SPI master: sends a 10-bit command word MSB first and, for
// rd-data commands, waits RD_WAIT turnaround cycles then receives one byte.
//
//  state | meaning
//  IDLE  | waiting for a command, SS_n high
//  CTRL  | one cycle presenting the frame-type bit (cmd[9])
//  SHIFT | ten cycles shifting the command word out MSB first
//  WAIT  | RD_WAIT turnaround cycles before read data (rd-data only)
//  RECV  | eight cycles sampling MISO MSB first (rd-data only)
//  DONE  | one cycle with SS_n high; publishes the read byte for rd-data
module spi_master_cmd #(
    parameter int RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [9:0] cmd,
    output logic       cmd_ready,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, CTRL, SHIFT, WAIT, RECV, DONE} state_t;

    localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

    state_t          state;
    logic [3:0]      cnt;
    logic [WW-1:0]   wcnt;
    logic [9:0]      tx;
    logic [7:0]      rx;
    logic            is_rd;

    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wcnt      <= '0;
            tx        <= 10'd0;
            rx        <= 8'h00;
            is_rd     <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        tx    <= cmd;
                        is_rd <= (cmd[9:8] == 2'b11);
                        rx    <= 8'h00;
                        SS_n  <= 1'b0;
                        MOSI  <= cmd[9];
                        state <= CTRL;
                    end
                end
                CTRL: begin
                    MOSI  <= tx[9];
                    cnt   <= 4'd9;
                    state <= SHIFT;
                end
                SHIFT: begin
                    // tx shifts left so the next bit to send is always tx[8]
                    if (cnt == 4'd0) begin
                        MOSI <= 1'b0;
                        if (is_rd) begin
                            if (RD_WAIT == 0) begin
                                cnt   <= 4'd7;
                                state <= RECV;
                            end else begin
                                wcnt  <= WAIT_LOAD;
                                state <= WAIT;
                            end
                        end else begin
                            SS_n  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        MOSI <= tx[8];
                        tx   <= {tx[8:0], 1'b0};
                        cnt  <= cnt - 4'd1;
                    end
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        cnt   <= 4'd7;
                        state <= RECV;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                RECV: begin
                    rx <= {rx[6:0], MISO};
                    if (cnt == 4'd0) begin
                        SS_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {rx[6:0], MISO};
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_cmd.md
SPI_MASTER_CMD -- requirements
Module: spi_master_cmd

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2, the number of turnaround cycles between the last command bit and the first read-data bit.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  host command request.
REQ-005 SHALL have port cmd  input  10  command word: [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-006 SHALL have port cmd_ready  output  1  high exactly when in IDLE and rst low.
REQ-007 SHALL have port SS_n  output  1  active-low slave select.
REQ-008 SHALL have port MOSI  output  1  serial data to the slave.
REQ-009 SHALL have port MISO  input  1  serial data from the slave.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle pulse marking a read-data response.
REQ-011 SHALL have port rsp_data  output  8  last received read byte.
REQ-012 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, CTRL, SHIFT, WAIT, RECV and DONE.
REQ-014 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1, register cmd internally, and go IDLE->CTRL; cmd_valid outside IDLE is ignored and no command is queued.
REQ-015 CTRL lasts 1 cycle: SS_n=0 and MOSI=cmd[9] (0 = write frame, 1 = read frame); then -> SHIFT.
REQ-016 SHIFT lasts 10 cycles: SS_n=0 and MOSI=cmd[9],cmd[8],...,cmd[0], MSB first, one bit per cycle, using a 4-bit counter.
REQ-017 After SHIFT, the next state is WAIT if opcode=11, otherwise DONE.
REQ-018 WAIT lasts RD_WAIT cycles (RD_WAIT=0 skips it): SS_n=0 and MOSI=0; then -> RECV.
REQ-019 RECV lasts 8 cycles: SS_n=0 and MOSI=0; MISO is sampled at the end of each cycle and shifted in MSB first; then -> DONE.
REQ-020 DONE lasts 1 cycle: SS_n=1 and MOSI=0; then -> IDLE.
REQ-021 For a rd-data frame only, DONE SHALL set rsp_valid=1 and rsp_data=the received byte.
REQ-022 rsp_data SHALL hold its value until the next rd-data DONE.
REQ-023 rsp_valid SHALL be 0 in every other cycle.
REQ-024 SS_n SHALL be 1 in IDLE and DONE, so consecutive frames are separated by at least 2 SS_n-high cycles.
REQ-025 Timing, with acceptance at edge 0: a write or rd-addr frame has SS_n low for cycles 1-11, DONE at cycle 12 and cmd_ready=1 at cycle 13.
REQ-026 Timing, with acceptance at edge 0: a rd-data frame has SS_n low for cycles 1..19+RD_WAIT and DONE at cycle 20+RD_WAIT.
REQ-027 Outputs SS_n, MOSI, rsp_valid, rsp_data and busy SHALL be registered or decoded from state only, with no combinational path from MISO.

Reset
REQ-028 While rst=1: state=IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_data=8'h00, busy=0 and cmd_ready=0, all taking effect immediately and asynchronously.
REQ-029 A reset asserted mid-frame SHALL abort the frame (SS_n returns to 1 at once) and discard the command and any partial read byte.
REQ-030 After rst deasserts, the block SHALL be in IDLE with cmd_ready=1 and no pending command.

Verification
REQ-031 SHALL cover: cmd=10'b00_0011_1100 accepted at edge 0 -> MOSI over cycles 1-11 = 0,0,0,0,0,1,1,1,1,0,0; SS_n low for cycles 1-11; no rsp_valid.
REQ-032 SHALL cover: cmd=10'b11_0000_0000 with RD_WAIT=2 and MISO driving 8'hA5 MSB first during cycles 14-21 -> rsp_valid=1 and rsp_data=8'hA5 at cycle 22 only.
REQ-033 SHALL cover: cmd_valid held high with a wr-addr then a wr-data command -> second acceptance at cycle 13, SS_n high for cycles 12-13, second frame MOSI control bit=0.
REQ-034 SHALL cover: cmd_valid pulsed with a new command during SHIFT -> that command is ignored, the frame completes unchanged, and busy=1 throughout cycles 1-12.
REQ-035 SHALL cover: rst asserted at cycle 15 of a rd-data frame -> SS_n=1, rsp_data=8'h00 and rsp_valid=0 immediately; after release, cmd_ready=1 and the next frame starts from CTRL.
REQ-036 SHALL cover: RD_WAIT=0 rd-data frame -> RECV at cycles 12-19, rsp_valid at cycle 20.
